// File: rtl/sysid_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sysid_arb_pkg
// Shared definitions for the system-ID read arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, ISSUE, RESP)
//   - ADDR_W      : sysid slave word-address width
//   - DEFAULT_DATA_W : default readdata width
//   - NUM_REQ_MAX : largest supported requester count
//   - idx_w()     : ptr/grant index width for a given requester count
// ---------------------------------------------------------------------------
package sysid_arb_pkg;

  localparam int ADDR_W         = 1;
  localparam int DEFAULT_DATA_W = 32;
  localparam int NUM_REQ_MAX    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // clog2 of the requester count, never narrower than one bit.
  function automatic int idx_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/sysid_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// sysid_read_arbiter_if
// Bundles the requester-side Avalon-MM read signals and the sysid slave
// signals of the arbiter.
//   req_read / req_address          : per-requester read request + word address
//   req_waitrequest                 : per-requester stall (low on accept cycle)
//   req_readdatavalid / req_readdata: one-hot response strobe + shared data
//   slv_address / slv_read          : access driven to the sysid slave
//   slv_readdata                    : combinational slave read data
// Modports:
//   slave  : the arbiter's view (it is the slave of the requesters)
//   master : the environment's view (requesters plus sysid slave)
// ---------------------------------------------------------------------------
interface sysid_read_arbiter_if
  import sysid_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEFAULT_DATA_W
);

  logic [NUM_REQ-1:0] req_read;
  logic [NUM_REQ-1:0] req_address;
  logic [NUM_REQ-1:0] req_waitrequest;
  logic [NUM_REQ-1:0] req_readdatavalid;
  logic [DATA_W-1:0]  req_readdata;
  logic [ADDR_W-1:0]  slv_address;
  logic               slv_read;
  logic [DATA_W-1:0]  slv_readdata;

  modport slave (
    input  req_read, req_address, slv_readdata,
    output req_waitrequest, req_readdatavalid, req_readdata,
           slv_address, slv_read
  );

  modport master (
    output req_read, req_address, slv_readdata,
    input  req_waitrequest, req_readdatavalid, req_readdata,
           slv_address, slv_read
  );

endinterface

// File: rtl/sysid_read_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req       in  : request vector
//   ptr       in  : index where the search starts (highest priority)
//   grant     out : one-hot winner
//   grant_idx out : encoded winner index
//   any_req   out : at least one request is present
// The pointer register lives in the parent.
// ---------------------------------------------------------------------------
module rr_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at ptr; the first one found wins, so the
  // lowest index at or after ptr (with wrap-around) has priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysid_read_arbiter.sv
// ---------------------------------------------------------------------------
// sysid_read_arbiter
// Round-robin read arbiter sharing one sysid slave between NUM_REQ
// Avalon-MM read requesters.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sysid_read_arbiter_if.slave (requester and slave signals)
// Parameters: NUM_REQ (2..8), DATA_W (readdata width).
// Optional feature macro SYSID_READ_CACHE_EN: when defined, each of the two
// slave words is cached after its first read and later reads are served
// from the cache without a slave access. Handshake timing is unchanged.
// ---------------------------------------------------------------------------
module sysid_read_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input logic            clock,
  input logic            reset,
  sysid_read_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   slv_addr_q, slv_addr_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [ADDR_W-1:0]   new_addr;

  logic [NUM_REQ-1:0]  wait_n;
  logic [NUM_REQ-1:0]  rdv;
  logic                slv_access;

`ifdef SYSID_READ_CACHE_EN
  logic [1:0][DATA_W-1:0] cache_data_q, cache_data_d;
  logic [1:0]             cache_valid_q, cache_valid_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (bus.req_read),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Address of whichever requester the picker selected this cycle.
  assign new_addr = |(arb_grant & bus.req_address);

  // Next-state and output logic. Arbitration happens in IDLE and again in
  // RESP, so a waiting requester is accepted right after the previous
  // response and throughput is one read every two cycles.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    data_d     = data_q;
    slv_addr_d = slv_addr_q;
    wait_n     = '1;
    rdv        = '0;
    slv_access = 1'b0;
`ifdef SYSID_READ_CACHE_EN
    cache_data_d  = cache_data_q;
    cache_valid_d = cache_valid_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          addr_d  = new_addr;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        wait_n[grant_q] = 1'b0;
`ifdef SYSID_READ_CACHE_EN
        // A hit leaves the slave untouched and serves the cached word.
        if (cache_valid_q[addr_q]) begin
          data_d = cache_data_q[addr_q];
        end else begin
          slv_access            = 1'b1;
          slv_addr_d            = addr_q;
          data_d                = bus.slv_readdata;
          cache_data_d[addr_q]  = bus.slv_readdata;
          cache_valid_d[addr_q] = 1'b1;
        end
`else
        slv_access = 1'b1;
        slv_addr_d = addr_q;
        data_d     = bus.slv_readdata;
`endif
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = RESP;
      end

      RESP: begin
        rdv[grant_q] = 1'b1;
        if (arb_any) begin
          grant_d = arb_idx;
          addr_d  = new_addr;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight transaction and restarts
  // arbitration from requester 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      slv_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      slv_addr_q <= slv_addr_d;
    end
  end

`ifdef SYSID_READ_CACHE_EN
  // Cache contents are only ever invalidated by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cache_data_q  <= '0;
      cache_valid_q <= '0;
    end else begin
      cache_data_q  <= cache_data_d;
      cache_valid_q <= cache_valid_d;
    end
  end
`endif

  // slv_address shows the new address during a real access and otherwise
  // keeps the address of the last access.
  assign bus.req_waitrequest   = wait_n;
  assign bus.req_readdatavalid = rdv;
  assign bus.req_readdata      = data_q;
  assign bus.slv_read          = slv_access;
  assign bus.slv_address       = slv_access ? addr_q : slv_addr_q;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sysid_read_arbiter
// Self-checking bench for sysid_read_arbiter (NUM_REQ = 2, DATA_W = 32).
// Directed scenarios plus a randomized run compared against a reference
// model built from the arbitration and timing rules. Honours
// SYSID_READ_CACHE_EN for the expected slave-access count.
// ---------------------------------------------------------------------------
module tb_sysid_read_arbiter;
  import sysid_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;
  int slv_pulses = 0;

  logic [DATA_W-1:0] slave_mem [2];

  always #5 clock = ~clock;

  sysid_read_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

  assign bus.slv_readdata = slave_mem[bus.slv_address];

  sysid_read_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Advance one clock and sample just after the edge; count slave strobes.
  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.slv_read === 1'b1) slv_pulses++;
  endtask

  task automatic apply_reset();
    reset           = 1'b1;
    bus.req_read    = '0;
    bus.req_address = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Round-robin choice: first requester at or after p (with wrap).
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      idx = (p + off) % NUM_REQ;
      if (((r >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset           = 1'b1;
    bus.req_read    = '1;
    bus.req_address = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.req_waitrequest !== 2'b11) begin
        errors++;
        $display("[TB] FAIL reset_wait cyc%0d: got %b expected 11", c, bus.req_waitrequest);
      end
      checks++;
      if (bus.req_readdatavalid !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_rdv cyc%0d: got %b expected 00", c, bus.req_readdatavalid);
      end
      checks++;
      if (bus.req_readdata !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_rdata cyc%0d: got %h expected 0", c, bus.req_readdata);
      end
      checks++;
      if (bus.slv_read !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_slv_read cyc%0d: got %b expected 0", c, bus.slv_read);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.req_waitrequest !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_first_accept: got %b expected 10", bus.req_waitrequest);
    end
    bus.req_read = '0;
    tick();
    tick();
  endtask

  task automatic test_single_read();
    apply_reset();
    slave_mem[1]    = 32'h513F9A6E;
    slave_mem[0]    = $urandom;
    slv_pulses      = 0;
    bus.req_read    = 2'b01;
    bus.req_address = 2'b01;
    tick();
    checks++;
    if (bus.req_waitrequest !== 2'b10 || bus.slv_read !== 1'b1 || bus.slv_address !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_accept: got wait=%b slv_read=%b addr=%b expected wait=10 slv_read=1 addr=1",
               bus.req_waitrequest, bus.slv_read, bus.slv_address);
    end
    tick();
    bus.req_read = '0;
    checks++;
    if (bus.req_readdatavalid !== 2'b01 || bus.req_readdata !== 32'h513F9A6E) begin
      errors++;
      $display("[TB] FAIL single_resp: got rdv=%b data=%h expected rdv=01 data=513f9a6e",
               bus.req_readdatavalid, bus.req_readdata);
    end
    tick();
    checks++;
    if (bus.req_readdatavalid !== 2'b00 || bus.req_readdata !== 32'h513F9A6E) begin
      errors++;
      $display("[TB] FAIL single_hold: got rdv=%b data=%h expected rdv=00 data=513f9a6e",
               bus.req_readdatavalid, bus.req_readdata);
    end
    checks++;
    if (slv_pulses !== 1) begin
      errors++;
      $display("[TB] FAIL single_pulses: got %0d expected 1", slv_pulses);
    end
  endtask

  task automatic test_address0();
    slave_mem[0]    = 32'h0;
    bus.req_read    = 2'b10;
    bus.req_address = 2'b00;
    tick();
    checks++;
    if (bus.req_waitrequest !== 2'b01) begin
      errors++;
      $display("[TB] FAIL addr0_accept: got %b expected 01", bus.req_waitrequest);
    end
    tick();
    bus.req_read = '0;
    checks++;
    if (bus.req_readdatavalid !== 2'b10 || bus.req_readdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL addr0_resp: got rdv=%b data=%h expected rdv=10 data=0",
               bus.req_readdatavalid, bus.req_readdata);
    end
    tick();
  endtask

  task automatic test_fairness();
    int order_idx;
    logic [NUM_REQ-1:0] exp_w;
    reset        = 1'b1;
    bus.req_read = '1;
    bus.req_address = '0;
    tick();
    tick();
    reset     = 1'b0;
    order_idx = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if ((c % 2) == 1) begin
        exp_w = ~(NUM_REQ'(1) << order_idx);
        order_idx = (order_idx + 1) % NUM_REQ;
      end else begin
        exp_w = '1;
      end
      checks++;
      if (bus.req_waitrequest !== exp_w) begin
        errors++;
        $display("[TB] FAIL fairness cyc%0d: got %b expected %b", c, bus.req_waitrequest, exp_w);
      end
    end
    bus.req_read = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req_read    = 2'b10;
    bus.req_address = 2'b10;
    tick();
    checks++;
    if (bus.req_waitrequest !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_issue: got %b expected 01", bus.req_waitrequest);
    end
    reset        = 1'b1;
    bus.req_read = 2'b11;
    tick();
    checks++;
    if (bus.req_readdatavalid !== 2'b00 || bus.req_waitrequest !== 2'b11 || bus.req_readdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_discard: got rdv=%b wait=%b data=%h expected rdv=00 wait=11 data=0",
               bus.req_readdatavalid, bus.req_waitrequest, bus.req_readdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.req_waitrequest !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mid_restart: got %b expected 10", bus.req_waitrequest);
    end
    tick();
    bus.req_read = 2'b10;
    checks++;
    if (bus.req_readdatavalid !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_resp0: got %b expected 01", bus.req_readdatavalid);
    end
    tick();
    checks++;
    if (bus.req_waitrequest !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_next1: got %b expected 01", bus.req_waitrequest);
    end
    tick();
    bus.req_read = '0;
    tick();
  endtask

  task automatic test_cache();
    int exp_pulses;
    apply_reset();
    slave_mem[1] = 32'h513F9A6E;
    slv_pulses   = 0;
    for (int r = 0; r < 2; r++) begin
      bus.req_read    = 2'b10;
      bus.req_address = 2'b10;
      tick();
      tick();
      bus.req_read = '0;
      checks++;
      if (bus.req_readdatavalid !== 2'b10 || bus.req_readdata !== 32'h513F9A6E) begin
        errors++;
        $display("[TB] FAIL cache_read%0d: got rdv=%b data=%h expected rdv=10 data=513f9a6e",
                 r, bus.req_readdatavalid, bus.req_readdata);
      end
      tick();
    end
`ifdef SYSID_READ_CACHE_EN
    exp_pulses = 1;
`else
    exp_pulses = 2;
`endif
    checks++;
    if (slv_pulses !== exp_pulses) begin
      errors++;
      $display("[TB] FAIL cache_pulses: got %0d expected %0d", slv_pulses, exp_pulses);
    end
  endtask

  // Random traffic. The model applies the rules directly: an accept happens
  // one cycle after requests are seen while the arbiter is free (i.e. not on
  // the cycle right after another accept), the winner follows round-robin
  // from the last winner, and the response follows the accept by one cycle.
  task automatic test_random();
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] paddr;
    logic [NUM_REQ-1:0] exp_w;
    logic [NUM_REQ-1:0] exp_rdv;
    logic [DATA_W-1:0]  last_data;
    logic [DATA_W-1:0]  prev_data;
    logic [1:0]         m_valid;
    logic               acc_addr;
    logic               exp_slv;
    int m_ptr;
    int prev_acc;
    int acc;
    apply_reset();
    slave_mem[0] = $urandom;
    slave_mem[1] = $urandom;
    pend      = '0;
    paddr     = '0;
    last_data = '0;
    prev_data = '0;
    m_valid   = '0;
    m_ptr     = 0;
    prev_acc  = -1;
    bus.req_read    = pend;
    bus.req_address = paddr;
    for (int cyc = 0; cyc < 400; cyc++) begin
      acc = (prev_acc < 0) ? rr_pick(pend, m_ptr) : -1;
      acc_addr = (acc >= 0) ? 1'((paddr >> acc)) : 1'b0;
      tick();

      exp_w   = (acc >= 0) ? ~(NUM_REQ'(1) << acc) : '1;
      exp_rdv = (prev_acc >= 0) ? (NUM_REQ'(1) << prev_acc) : '0;
      if (prev_acc >= 0) last_data = prev_data;
`ifdef SYSID_READ_CACHE_EN
      exp_slv = (acc >= 0) && !m_valid[acc_addr];
`else
      exp_slv = (acc >= 0);
`endif
      checks++;
      if (bus.req_waitrequest !== exp_w) begin
        errors++;
        $display("[TB] FAIL rand_wait cyc%0d: got %b expected %b", cyc, bus.req_waitrequest, exp_w);
      end
      checks++;
      if (bus.req_readdatavalid !== exp_rdv) begin
        errors++;
        $display("[TB] FAIL rand_rdv cyc%0d: got %b expected %b", cyc, bus.req_readdatavalid, exp_rdv);
      end
      checks++;
      if (bus.req_readdata !== last_data) begin
        errors++;
        $display("[TB] FAIL rand_data cyc%0d: got %h expected %h", cyc, bus.req_readdata, last_data);
      end
      checks++;
      if (bus.slv_read !== exp_slv || (exp_slv && bus.slv_address !== acc_addr)) begin
        errors++;
        $display("[TB] FAIL rand_slv cyc%0d: got read=%b addr=%b expected read=%b addr=%b",
                 cyc, bus.slv_read, bus.slv_address, exp_slv, acc_addr);
      end

      // The requester accepted last cycle has passed its accept edge and
      // releases its request; the one just accepted must still hold.
      if (prev_acc >= 0) pend = pend & ~(NUM_REQ'(1) << prev_acc);
      if (acc >= 0) begin
        m_valid[acc_addr] = 1'b1;
        prev_data = slave_mem[acc_addr];
        m_ptr     = (acc + 1) % NUM_REQ;
      end
      prev_acc = acc;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (((pend >> i) & 1) == 0 && i != acc && $urandom_range(0, 2) == 0) begin
          pend  = pend | (NUM_REQ'(1) << i);
          if ($urandom_range(0, 1) == 1) paddr = paddr | (NUM_REQ'(1) << i);
          else                           paddr = paddr & ~(NUM_REQ'(1) << i);
        end
      end
      bus.req_read    = pend;
      bus.req_address = paddr;
    end
    bus.req_read = '0;
    tick();
    tick();
  endtask

  initial begin
    bus.req_read    = '1;
    bus.req_address = '0;
    slave_mem[0]    = '0;
    slave_mem[1]    = '0;
    test_reset();
    test_single_read();
    test_address0();
    test_fairness();
    test_reset_mid();
    test_cache();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_read_arbiter.md
# sysid_read_arbiter

Round-robin read arbiter that shares the single system-ID slave among NUM_REQ Avalon-MM read requesters. Each requester sees its own waitrequest/readdatavalid. The requesters share one registered readdata bus. The block sits between the requesting masters (CPU data master, debug/boot sequencer, host bridge) and the sysid control slave. It owns the slave's address and read strobe.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- DATA_W, 32: readdata width.

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read request; held high until waitrequest is low.
- req_address  in  NUM_REQ  per-requester word address (1 bit each: 0 = ID word, 1 = timestamp word).
- req_waitrequest  out  NUM_REQ  per-requester stall; low for exactly the accept cycle.
- req_readdatavalid  out  NUM_REQ  one-hot, single-cycle response strobe.
- req_readdata  out  DATA_W  shared registered response data; qualified by req_readdatavalid.
- slv_address  out  1  address driven to the sysid slave.
- slv_read  out  1  single-cycle strobe marking a real slave access.
- slv_readdata  in  DATA_W  combinational slave read data.

## Operation
- State machine states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_read is high, pick a winner by round-robin, starting the search at ptr.
  - Latch the grant index and that requester's address.
  - Go to ISSUE.
- ISSUE:
  - Drive slv_address = latched address and slv_read = 1.
  - Drive req_waitrequest[grant] = 0; all other waitrequest bits stay 1.
  - Capture slv_readdata into the data register.
  - Set ptr = (grant+1) mod NUM_REQ.
  - Go to RESP.
- RESP:
  - Drive req_readdatavalid[grant] = 1 and present the registered data on req_readdata.
  - Arbitrate again in this same cycle. If any req_read is high, latch the new grant and go to ISSUE; otherwise go to IDLE.
- Arbitration sampling:
  - The granted requester's req_read is not re-sampled in ISSUE.
  - Dropping req_read before its accept cycle is an Avalon protocol violation; the transaction completes regardless.
  - A requester that drops req_read before it is granted is simply never granted.
- req_readdata holds its last value when no readdatavalid is asserted.
- slv_address holds its last value outside ISSUE.
- Reset values:
  - req_waitrequest = all 1; req_readdatavalid = 0; req_readdata = 0.
  - slv_address = 0; slv_read = 0.
  - state = IDLE; ptr = 0; grant = 0.
- Reset mid-operation:
  - Reset overrides every transition.
  - An in-flight transaction is discarded, with no readdatavalid.
  - Arbitration resumes from requester 0.
- Simultaneous requests: the lowest index at or after ptr wins; the others wait.

## Timing
- Request first seen high in IDLE at cycle N:
  - accept (waitrequest low) at N+1;
  - readdatavalid with data at N+2.
- Back-to-back throughput: one read every 2 cycles (RESP overlaps the next arbitration).
- Worst-case wait for any continuously asserted requester: 2·NUM_REQ cycles from first sample to accept.
- slv_readdata is sampled only in the ISSUE cycle; the slave must be combinational or zero-wait.

## Configuration
- Macro: SYSID_READ_CACHE_EN.
- Defined:
  - Two DATA_W cache registers plus two valid bits, one per address, are cleared by reset only.
  - First ISSUE to an address reads the slave (slv_read = 1) and fills the cache entry.
  - Later ISSUE cycles to a valid entry keep slv_read = 0 and slv_address unchanged, and take data from the cache.
  - Handshake timing is identical to the undefined case.
- Undefined: every ISSUE performs a slave access; no cache storage is generated.

## Structure
- Package sysid_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - constants for address width (1) and the default DATA_W;
  - the NUM_REQ maximum (8);
  - the ptr/grant index width, derived as clog2 of NUM_REQ.
- Sub-module rr_arbiter:
  - inputs: req vector, ptr;
  - outputs: one-hot grant, encoded index, any_req;
  - purely combinational;
  - the pointer register stays in the parent.

## Test plan
- Reset: hold reset 3 cycles with requests active -> req_waitrequest = all 1, req_readdatavalid = 0, req_readdata = 0, slv_read = 0 throughout; first accept is 1 cycle after reset deasserts.
- Single read: req_read[0] = 1, address 1, slave returns 0x513F9A6E -> waitrequest[0] low at N+1, readdatavalid[0] and req_readdata = 0x513F9A6E at N+2, one slv_read pulse.
- Address 0: req1 reads address 0, slave returns 0x00000000 -> req_readdata = 0, readdatavalid[1] only.
- Fairness: both requesters continuously asserted from reset -> accept order 0, 1, 0, 1, with accepts spaced 2 cycles and no requester accepted twice in a row.
- Reset mid-transaction: assert reset during ISSUE for requester 1 -> no readdatavalid; after reset, requester 0 wins a simultaneous request.
- Cache: requester 1 reads address 1 twice -> both return 0x513F9A6E; slv_read pulses once with SYSID_READ_CACHE_EN, twice without.
